// File: rtl/div_nr_seq_if.sv
// Handshake and operand/result bundle between a controller and the
// sequential divider.
interface div_nr_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_nr_seq.sv
// Sequential non-restoring divider working on operand magnitudes, one
// quotient bit per cycle, with signed/unsigned mode and fixed latency.
module div_nr_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  div_nr_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;

  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_mag_reg, b_mag_reg, a_raw_reg;
  logic             q_neg_reg, r_neg_reg, dz_reg, ov_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg;
  logic             dz_out_reg, ov_out_reg, done_reg;
  logic             busy;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   p_shift, b_ext, p_new;
  logic [WIDTH-1:0] r_mag, q_final, r_final;

  // Magnitude of the most negative value wraps onto itself and is read unsigned.
  assign a_neg = bus.signed_mode & bus.dividend[WIDTH-1];
  assign b_neg = bus.signed_mode & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? (ZERO - bus.dividend) : bus.dividend;
  assign b_mag = b_neg ? (ZERO - bus.divisor) : bus.divisor;

  assign b_ext   = {1'b0, b_mag_reg};
  assign p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign p_new   = p_reg[WIDTH] ? (p_shift + b_ext) : (p_shift - b_ext);

  // P lies in [-D, D), so the restored remainder fits in WIDTH bits.
  assign r_mag   = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + b_mag_reg) : p_reg[WIDTH-1:0];
  assign q_final = q_neg_reg ? (ZERO - q_reg) : q_reg;
  assign r_final = r_neg_reg ? (ZERO - r_mag) : r_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: state_next = CALC;
      CALC: if (cnt_reg == CNT_W'(1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_reg      <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      a_raw_reg  <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      ov_reg     <= 1'b0;
      quot_reg   <= '0;
      rem_reg    <= '0;
      dz_out_reg <= 1'b0;
      ov_out_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.start) begin
          a_mag_reg  <= a_mag;
          b_mag_reg  <= b_mag;
          a_raw_reg  <= bus.dividend;
          q_neg_reg  <= a_neg ^ b_neg;
          r_neg_reg  <= a_neg;
          dz_reg     <= (bus.divisor == ZERO);
          ov_reg     <= bus.signed_mode && (bus.dividend == MOST_NEG) && (bus.divisor == ONES);
          dz_out_reg <= 1'b0;
          ov_out_reg <= 1'b0;
        end
        LOAD: begin
          p_reg   <= '0;
          q_reg   <= a_mag_reg;
          cnt_reg <= CNT_W'(WIDTH);
        end
        CALC: begin
          p_reg   <= p_new;
          q_reg   <= {q_reg[WIDTH-2:0], ~p_new[WIDTH]};
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        FIX: begin
          done_reg   <= 1'b1;
          dz_out_reg <= dz_reg;
          ov_out_reg <= ov_reg;
          if (dz_reg) begin
            quot_reg <= ONES;
            rem_reg  <= a_raw_reg;
          end else if (ov_reg) begin
            quot_reg <= a_raw_reg;
            rem_reg  <= ZERO;
          end else begin
            quot_reg <= q_final;
            rem_reg  <= r_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_reg;
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dz_out_reg;
  assign bus.overflow    = ov_out_reg;
endmodule
